// File: rtl/csa_sum_accumulator.sv
// Accumulates a programmed number of {c,s} terms from the carry-select adder into an ACC_W-bit total.
// Optional macro CSA_ACC_SATURATE_EN: clamp acc to all-ones on overflow instead of wrapping.
//
// state | meaning
// IDLE  | waiting for start; acc/ovf hold the previous result
// ACCUM | accepting one term per cycle until remaining reaches zero
// DONE  | result presented on acc/ovf with out_valid until out_ready
module csa_sum_accumulator #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_terms,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] s,
  input  logic              c,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  acc,
  output logic              ovf,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   remaining;
  logic [ACC_W:0]     sum_ext;
  logic               take;

  assign take    = in_valid && (state == ACCUM);
  // One extra bit on the left captures the carry out of the accumulator MSB.
  assign sum_ext = {1'b0, acc} + {{(ACC_W-DATA_W){1'b0}}, c, s};

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (num_terms == '0) ? DONE : ACCUM;
      ACCUM:   if (take && remaining == CNT_W'(1)) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      ovf       <= 1'b0;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc       <= '0;
            ovf       <= 1'b0;
            remaining <= num_terms;
          end
        end
        ACCUM: begin
          if (take) begin
            remaining <= remaining - CNT_W'(1);
            ovf       <= ovf | sum_ext[ACC_W];
`ifdef CSA_ACC_SATURATE_EN
            // Once clamped, the total stays pinned for the rest of the run.
            if (ovf || sum_ext[ACC_W]) acc <= '1;
            else                       acc <= sum_ext[ACC_W-1:0];
`else
            acc <= sum_ext[ACC_W-1:0];
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/csa_sum_accumulator.md
Name: csa_sum_accumulator

Overview:
Downstream stage of the 8-bit carry_select_adder. It consumes the adder's sum `s` and carry-out `c` as a 9-bit term over a valid/ready handshake and accumulates a programmed number of terms into a wider register. The final total is presented with its own valid/ready handshake. Used to build multi-operand sums, for example checksums or running totals, from the single-cycle adder.

Parameters:
DATA_W, 8, width of adder sum input `s`; the term is {c,s}, DATA_W+1 bits.
ACC_W, 16, accumulator width; must be >= DATA_W+1.
CNT_W, 4, width of num_terms; up to 2^CNT_W-1 terms per run.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  one-cycle pulse that begins a run; honoured only in IDLE.
num_terms  input  CNT_W  number of terms in the run; sampled when start is accepted.
in_valid  input  1  s and c hold a valid term.
in_ready  output  1  block accepts a term this cycle.
s  input  DATA_W  sum from carry_select_adder.
c  input  1  carry-out from carry_select_adder.
out_valid  output  1  acc holds the final result.
out_ready  input  1  consumer takes the result.
acc  output  ACC_W  accumulated value.
ovf  output  1  sticky flag: a carry out of the ACC_W MSB occurred during the run.
busy  output  1  high in ACCUM and DONE.

Behaviour:
- Reset is asynchronous and active-high; clk is the single clock. On reset: state=IDLE, acc=0, ovf=0, out_valid=0, in_ready=0, busy=0, remaining counter=0.
- FSM states: IDLE, ACCUM, DONE. All outputs are decoded from registered state or registers; there is no combinational input-to-output path.
- IDLE:
  - in_ready=0, out_valid=0, busy=0; acc and ovf hold their last values.
  - start with num_terms!=0: go to ACCUM, acc<=0, ovf<=0, remaining<=num_terms.
  - start with num_terms==0: go to DONE, acc<=0, ovf<=0.
- ACCUM:
  - in_ready=1.
  - On in_valid&&in_ready: acc<=acc+zero_extend({c,s}) mod 2^ACC_W; ovf<=ovf | carry out of bit ACC_W-1; remaining<=remaining-1.
  - A term accepted when remaining==1 moves the FSM to DONE.
  - in_valid=0 stalls with no change. start is ignored.
- DONE:
  - out_valid=1, in_ready=0; acc and ovf are stable.
  - On out_ready: go to IDLE; out_valid drops the next cycle.
  - start is ignored while out_valid is high, including in the same cycle as out_ready.
- Latency: out_valid rises the cycle after the last term is accepted. A run of N terms with in_valid held high takes N cycles in ACCUM plus 1 cycle to out_valid.
- Throughput: one term per cycle in ACCUM.
- Term arithmetic: term = c*2^DATA_W + s, range 0..2^(DATA_W+1)-1.
- Reset asserted mid-run: immediate return to IDLE with all registers cleared; any partial sum is discarded.
- Terms presented in IDLE or DONE are not accepted and not consumed.

Optional Feature:
Macro CSA_ACC_SATURATE_EN.
- Defined: on overflow acc clamps to 2^ACC_W-1 and stays there for the rest of the run; ovf is set as usual.
- Undefined: acc wraps modulo 2^ACC_W; ovf is set.
- In both builds ovf is cleared at start and never by overflow logic.

Test Plan:
- Reset mid-run:
  - Stimulus: assert rst during ACCUM after 2 terms.
  - Response: outputs immediately 0, state IDLE.
  - Follow-up: a new start with num_terms=1 and term 5 gives acc=5.
- Basic sum:
  - Stimulus: start, num_terms=6, back-to-back {c,s}={0,3},{0,1},{0,8},{0,11},{0,15},{0,12}.
  - Response: out_valid 1 cycle after the 6th accept; acc=16'h0032; ovf=0.
- Carry term plus stalls:
  - Stimulus: num_terms=2, terms {1,8'hFF} and {1,8'h01}, with in_valid low for 3 cycles between them.
  - Response: acc=16'h0300 (511+257=768); in_ready stays high; no term is lost or duplicated.
- Overflow (ACC_W=10):
  - Stimulus: num_terms=3, terms 511, 511, 2.
  - Response without CSA_ACC_SATURATE_EN: acc=0, ovf=1.
  - Response with CSA_ACC_SATURATE_EN: acc=1023, ovf=1.
- Output backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles in DONE while pulsing start and driving in_valid.
  - Response: acc stable, out_valid high, in_ready=0, start ignored.
  - Follow-up: out_ready=1 returns the FSM to IDLE; out_valid is 0 the next cycle.
- Zero terms:
  - Stimulus: start with num_terms=0.
  - Response: out_valid the next cycle with acc=0, ovf=0; in_ready never asserted.
